string_blit_ctrl: RTL and testbench
===================================

// Module: string_blit_ctrl
// PURPOSE
//  Sequencer that copies NUL-terminated strings from the strings ROM into the
//  text-mode character RAM at a requested row/col; one char per clock.
//  Sits between the UI/label logic (requester) and the text RAM write port.
//  Requester issues (rom start address, row, col); block walks the ROM until NUL.
// PARAMETERS
//  COLS     80   text columns per row
//  ROWS     30   text rows
//  MAX_LEN  64   hard cap on chars per request (guards unterminated strings)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   block idle, can accept request
//  req_addr   in   11  ROM address of first char
//  req_row    in   5   destination row (0..ROWS-1)
//  req_col    in   7   destination col (0..COLS-1)
//  rom_addr   out  11  strings ROM address (ROM is combinational, data same cycle)
//  rom_data   in   8   strings ROM char; 8'h00 = terminator
//  txt_we     out  1   text RAM write enable (registered)
//  txt_addr   out  12  text RAM address = row*COLS+col (registered)
//  txt_data   out  8   char to write (registered)
//  busy       out  1   high while in RUN
//  done       out  1   one-cycle pulse at end of request
//  done_len   out  7   chars written by the finished request, valid with done
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; txt_we=0; done=0; busy=0; rom_addr, txt_addr,
//   txt_data, done_len = 0. Reset mid-RUN aborts: no done pulse, txt_we=0 next cycle.
//  Handshake: accept on clk edge with req_valid&&req_ready; req_ready=0 in RUN;
//   requests while busy are not accepted (requester holds req_valid).
//  States: IDLE -> RUN on accept (latch rom_addr=req_addr, row, col, len=0).
//   RUN, each cycle: if rom_data==0 or len==MAX_LEN -> IDLE, done=1, done_len=len;
//   else register txt_we=1, txt_addr=cursor, txt_data=rom_data; rom_addr+1; len+1;
//   advance cursor.
//  Timing (accept cycle = 0, N chars): RUN cycles 1..N+1; writes visible in
//   cycles 2..N+1; done in cycle N+2 with req_ready=1; next accept earliest N+2.
//  Empty string (first char NUL): no writes, done in cycle 2, done_len=0.
//  Cursor: col+1; at col==COLS-1 wraps to col 0, row+1; write at row==ROWS-1,
//   col==COLS-1 is last: terminate after it (done next cycle, len counts it).
//  rom_addr wraps 2047->0 (MAX_LEN bounds runaway). txt_we=0 in every non-write cycle.
//  Out-of-range req_row/req_col: request accepted, done next RUN cycle, len=0.
// CONFIGURATION
//  STR_BLIT_CLIP_EN defined: no wrap; chars past col COLS-1 are read and counted
//   toward MAX_LEN but not written (txt_we=0); done_len counts written chars only;
//   termination still on NUL/MAX_LEN.
//  Undefined: wrap-to-next-row behaviour above.
// STRUCTURE
//  Package str_blit_pkg: COLS/ROWS defaults, ROM_AW=11, TXT_AW=12, CHAR_W=8,
//   CHAR_NUL=8'h00, FSM state enum {IDLE,RUN}.
//  Sub-module txt_cursor: row/col counters plus incremental linear address
//   (add 1 per step; no multiplier after load), wrap/end-of-screen flags.
// TESTING
//  req_addr=1,row=0,col=33 on "MASTER SCOPE!" -> 13 writes addr 33..45,
//   data "M".."!", done at cycle 15, done_len=13.
//  req_addr=14 (NUL) -> no txt_we, done at cycle 2, done_len=0.
//  req_addr=15 ("Ch1 Vdiv:"), row=2,col=76 -> addrs 236..239 then 240..244
//   (row 3), done_len=9; with STR_BLIT_CLIP_EN -> 4 writes 236..239, done_len=4.
//  ROM model with no NUL from addr 2040 -> exactly 64 writes, rom_addr wraps
//   2047->0, done_len=64.
//  req_valid held during busy, second request queued -> accepted in done cycle,
//   first write of 2nd string two cycles later, no overlap of writes.
//  reset asserted at RUN cycle 5 -> txt_we=0, busy=0, req_ready=1 next cycle, no done.

Source files
------------

// File: rtl/str_blit_pkg.sv
// Package: str_blit_pkg
// Shared constants, types and helpers for the string blitter.
//   DEF_COLS / DEF_ROWS / DEF_MAX_LEN : default text geometry and length cap
//   ROM_AW / TXT_AW / CHAR_W          : strings ROM address, text RAM address, char widths
//   CHAR_NUL                          : string terminator
//   state_t                           : sequencer state {IDLE, RUN}
// Optional feature macro: STR_BLIT_CLIP_EN. When defined, text is clipped at the
// right-hand edge of the row instead of wrapping to the next row.
package str_blit_pkg;

  localparam int DEF_COLS    = 80;
  localparam int DEF_ROWS    = 30;
  localparam int DEF_MAX_LEN = 64;

  localparam int ROM_AW = 11;
  localparam int TXT_AW = 12;
  localparam int CHAR_W = 8;
  localparam int ROW_W  = 5;
  localparam int COL_W  = 7;
  localparam int LEN_W  = 7;

  localparam logic [CHAR_W-1:0] CHAR_NUL = 8'h00;

`ifdef STR_BLIT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when the requested destination lies on the screen.
  function automatic logic coord_ok(input logic [ROW_W-1:0] row,
                                    input logic [COL_W-1:0] col,
                                    input int               rows,
                                    input int               cols);
    coord_ok = (int'(row) < rows) && (int'(col) < cols);
  endfunction

  // Linear text RAM address of a cell; only used when a cursor is loaded.
  function automatic logic [TXT_AW-1:0] lin_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col,
                                                 input int               cols);
    lin_addr = TXT_AW'((int'(row) * cols) + int'(col));
  endfunction

endpackage

// File: rtl/txt_cursor.sv
// Module: txt_cursor
// Text-mode write cursor: row/col counters plus a linear RAM address that is
// computed once on load and afterwards advanced by one per step.
//   clk, reset : clock, synchronous active-high reset
//   load       : take row_in/col_in as the new cursor position
//   step       : advance one cell (wraps to the next row, or clips when
//                STR_BLIT_CLIP_EN is defined)
//   addr       : linear text RAM address of the current cell
//   last_cell  : cursor sits on the bottom-right cell of the screen
//   clipped    : cursor has run off the right edge (clip build only)
module txt_cursor
  import str_blit_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ROW_W-1:0]  row_in,
  input  logic [COL_W-1:0]  col_in,
  output logic [TXT_AW-1:0] addr,
  output logic              last_cell,
  output logic              clipped
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;
  logic             clip_r;

  // Cursor position, linear address and clip flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_r  <= {ROW_W{1'b0}};
      col_r  <= {COL_W{1'b0}};
      addr   <= {TXT_AW{1'b0}};
      clip_r <= 1'b0;
    end else if (load) begin
      row_r  <= row_in;
      col_r  <= col_in;
      addr   <= lin_addr(row_in, col_in, COLS);
      clip_r <= 1'b0;
    end else if (step) begin
      if (col_r == LAST_COL) begin
        if (CLIP_EN) begin
          clip_r <= 1'b1;
        end else begin
          // Row-major layout: the next row's first cell is simply addr+1.
          col_r <= {COL_W{1'b0}};
          row_r <= row_r + 5'd1;
          addr  <= addr + 12'd1;
        end
      end else begin
        col_r <= col_r + 7'd1;
        addr  <= addr + 12'd1;
      end
    end else begin
      clip_r <= clip_r;
    end
  end

  assign last_cell = (row_r == LAST_ROW) && (col_r == LAST_COL);
  assign clipped   = clip_r;

endmodule

// File: rtl/string_blit_ctrl.sv
// Module: string_blit_ctrl
// Copies a NUL-terminated string from the combinational strings ROM into the
// text-mode character RAM, one character per clock, starting at row/col.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (accept when both high)
//   req_addr/row/col    : ROM start address and destination cell
//   rom_addr/rom_data   : strings ROM port (data valid in the same cycle)
//   txt_we/addr/data    : registered text RAM write port
//   busy                : high while a string is being copied
//   done/done_len       : one-cycle completion pulse and chars written
// Optional feature macro: STR_BLIT_CLIP_EN (clip at row end instead of wrap).
module string_blit_ctrl
  import str_blit_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ROM_AW-1:0] req_addr,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [COL_W-1:0]  req_col,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [CHAR_W-1:0] rom_data,
  output logic              txt_we,
  output logic [TXT_AW-1:0] txt_addr,
  output logic [CHAR_W-1:0] txt_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  done_len
);

  localparam logic [LEN_W-1:0] LEN_CAP = LEN_W'(MAX_LEN);

  state_t            state_r;
  logic [LEN_W-1:0]  len_r;     // chars read, bounds runaway strings
  logic [LEN_W-1:0]  wr_len_r;  // chars actually written
  logic              stop_r;    // forces termination on the next RUN cycle

  logic              accept_s;
  logic              finish_s;
  logic              write_s;
  logic [TXT_AW-1:0] cur_addr_s;
  logic              cur_last_s;
  logic              cur_clip_s;

  txt_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_s),
    .step      (write_s),
    .row_in    (req_row),
    .col_in    (req_col),
    .addr      (cur_addr_s),
    .last_cell (cur_last_s),
    .clipped   (cur_clip_s)
  );

  // Decode what the sequencer does in the current cycle.
  always_comb begin
    accept_s = 1'b0;
    finish_s = 1'b0;
    write_s  = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = req_valid;
      end
      RUN: begin
        finish_s = stop_r || (len_r == LEN_CAP) || (rom_data == CHAR_NUL);
        write_s  = !finish_s && !cur_clip_s;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered handshake, ROM address and RAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rom_addr  <= {ROM_AW{1'b0}};
      txt_we    <= 1'b0;
      txt_addr  <= {TXT_AW{1'b0}};
      txt_data  <= {CHAR_W{1'b0}};
      done      <= 1'b0;
      done_len  <= {LEN_W{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      wr_len_r  <= {LEN_W{1'b0}};
      stop_r    <= 1'b0;
    end else begin
      txt_we <= 1'b0;
      done   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r   <= RUN;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            rom_addr  <= req_addr;
            len_r     <= {LEN_W{1'b0}};
            wr_len_r  <= {LEN_W{1'b0}};
            // Off-screen destinations finish on the first RUN cycle.
            stop_r    <= !coord_ok(req_row, req_col, ROWS, COLS);
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        RUN: begin
          if (finish_s) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            done_len  <= wr_len_r;
            stop_r    <= 1'b0;
          end else begin
            rom_addr <= rom_addr + 11'd1;
            len_r    <= len_r + 7'd1;
            if (write_s) begin
              txt_we   <= 1'b1;
              txt_addr <= cur_addr_s;
              txt_data <= rom_data;
              wr_len_r <= wr_len_r + 7'd1;
              // Bottom-right cell is the last one the screen can take.
              if (cur_last_s && !CLIP_EN) begin
                stop_r <= 1'b1;
              end else begin
                stop_r <= stop_r;
              end
            end else begin
              wr_len_r <= wr_len_r;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_string_blit_ctrl.sv
// Testbench for string_blit_ctrl: directed and randomized requests checked
// against a reference model that derives the expected writes, timing and
// length directly from the string copy rules.
module tb_string_blit_ctrl;

  localparam int COLS    = 80;
  localparam int ROWS    = 30;
  localparam int MAX_LEN = 64;
`ifdef STR_BLIT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_addr;
  logic [4:0]  req_row;
  logic [6:0]  req_col;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        txt_we;
  logic [11:0] txt_addr;
  logic [7:0]  txt_data;
  logic        busy;
  logic        done;
  logic [6:0]  done_len;

  logic [7:0]  rom [0:2047];

  int checks;
  int errors;
  int exp_addr_q[$];
  int exp_data_q[$];
  int exp_reads;

  string_blit_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_row   (req_row),
    .req_col   (req_col),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .txt_we    (txt_we),
    .txt_addr  (txt_addr),
    .txt_data  (txt_data),
    .busy      (busy),
    .done      (done),
    .done_len  (done_len)
  );

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_str(input int base, input string s);
    for (int i = 0; i < s.len(); i++) rom[base + i] = s[i];
    rom[base + s.len()] = 8'h00;
  endtask

  // Reference model: list of cells written and number of chars consumed.
  task automatic model(input int a, input int r, input int c);
    logic [7:0] ch;
    int pos;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_reads = 0;
    if (r < ROWS && c < COLS) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        ch = rom[(a + i) % 2048];
        if (ch == 8'h00) break;
        exp_reads++;
        pos = r * COLS + c + i;
        if (CLIP) begin
          if (c + i < COLS) begin
            exp_addr_q.push_back(pos);
            exp_data_q.push_back(int'(ch));
          end
        end else begin
          exp_addr_q.push_back(pos);
          exp_data_q.push_back(int'(ch));
          if (pos == ROWS * COLS - 1) break;
        end
      end
    end
  endtask

  // Present a request; called just after a falling edge with the DUT idle.
  task automatic issue(input string tag, input int a, input int r, input int c);
    req_addr  = 11'(a);
    req_row   = 5'(r);
    req_col   = 7'(c);
    req_valid = 1'b1;
    chk({tag, "/ready"}, int'(req_ready), 1);
  endtask

  // Follow one request from its accept edge to its done pulse.
  task automatic collect(input string tag, input int a, input int r, input int c,
                         input bit chain, input int na, input int nr, input int nc);
    int  widx;
    bit  got_done;
    model(a, r, c);
    @(posedge clk);
    #1;
    if (chain) begin
      req_addr = 11'(na);
      req_row  = 5'(nr);
      req_col  = 7'(nc);
    end else begin
      req_valid = 1'b0;
    end
    widx     = 0;
    got_done = 1'b0;
    for (int k = 1; k <= 80 && !got_done; k++) begin
      @(negedge clk);
      if (txt_we) begin
        if (widx < exp_addr_q.size()) begin
          chk({tag, "/waddr"}, int'(txt_addr), exp_addr_q[widx]);
          chk({tag, "/wdata"}, int'(txt_data), exp_data_q[widx]);
          chk({tag, "/wcyc"}, k, widx + 2);
        end
        widx++;
      end
      if (done) begin
        got_done = 1'b1;
        chk({tag, "/done_cyc"}, k, exp_reads + 2);
        chk({tag, "/done_len"}, int'(done_len), exp_addr_q.size());
        chk({tag, "/ready_at_done"}, int'(req_ready), 1);
        chk({tag, "/busy_at_done"}, int'(busy), 0);
      end else begin
        chk({tag, "/busy"}, int'(busy), 1);
      end
    end
    chk({tag, "/nwrites"}, widx, exp_addr_q.size());
    chk({tag, "/done_seen"}, int'(got_done), 1);
  endtask

  initial begin
    int a;
    int r;
    int c;
    int nd;
    checks    = 0;
    errors    = 0;
    clk       = 1'b0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 11'd0;
    req_row   = 5'd0;
    req_col   = 7'd0;

    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    load_str(1, "MASTER SCOPE!");
    load_str(15, "Ch1 Vdiv:");
    load_str(30, "ABCDEFGHI");
    for (int i = 200; i < 2000; i++)
      rom[i] = ($urandom_range(0, 11) == 0) ? 8'h00 : 8'($urandom_range(32, 126));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst/ready", int'(req_ready), 1);
    chk("rst/txt_we", int'(txt_we), 0);
    chk("rst/done", int'(done), 0);
    chk("rst/busy", int'(busy), 0);
    chk("rst/rom_addr", int'(rom_addr), 0);
    chk("rst/txt_addr", int'(txt_addr), 0);
    chk("rst/txt_data", int'(txt_data), 0);
    chk("rst/done_len", int'(done_len), 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed strings
    issue("master", 1, 0, 33);   collect("master", 1, 0, 33, 1'b0, 0, 0, 0);
    issue("empty", 14, 5, 5);    collect("empty", 14, 5, 5, 1'b0, 0, 0, 0);
    issue("vdiv", 15, 2, 76);    collect("vdiv", 15, 2, 76, 1'b0, 0, 0, 0);
    issue("eos", 30, 29, 77);    collect("eos", 30, 29, 77, 1'b0, 0, 0, 0);
    issue("oor_row", 1, 30, 0);  collect("oor_row", 1, 30, 0, 1'b0, 0, 0, 0);
    issue("oor_col", 1, 3, 80);  collect("oor_col", 1, 3, 80, 1'b0, 0, 0, 0);

    // Back-to-back: second request held valid while the first runs
    issue("q1", 1, 0, 33);
    collect("q1", 1, 0, 33, 1'b1, 15, 2, 76);
    collect("q2", 15, 2, 76, 1'b0, 0, 0, 0);

    // Randomized requests
    for (int n = 0; n < 14; n++) begin
      a = $urandom_range(200, 1950);
      r = $urandom_range(0, 31);
      c = $urandom_range(0, 85);
      issue("rand", a, r, c);
      collect("rand", a, r, c, 1'b0, 0, 0, 0);
    end

    // Reset in RUN cycle 5 aborts without a done pulse
    issue("abort", 1, 0, 33);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort/txt_we", int'(txt_we), 0);
    chk("abort/busy", int'(busy), 0);
    chk("abort/ready", int'(req_ready), 1);
    chk("abort/done", int'(done), 0);
    reset = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort/no_done", nd, 0);
    issue("after_abort", 1, 0, 33); collect("after_abort", 1, 0, 33, 1'b0, 0, 0, 0);

    // Unterminated string wrapping the ROM address space
    for (int i = 2040; i < 2048; i++) rom[i] = 8'(8'h41 + (i % 26));
    for (int i = 0; i < 100; i++) rom[i] = 8'(8'h61 + (i % 26));
    issue("runaway", 2040, 0, 0);  collect("runaway", 2040, 0, 0, 1'b0, 0, 0, 0);
    issue("runaway2", 2040, 5, 40); collect("runaway2", 2040, 5, 40, 1'b0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
